// File: rtl/parking_pkg.sv
// Shared widths and queue-select encodings for the parking record buffer.
package parking_pkg;
   localparam int TOKEN_W_DEF = 3;
   localparam int TIME_W_DEF  = 8;
   localparam int REC_W_DEF   = TOKEN_W_DEF + TIME_W_DEF;

   localparam logic SEL_P = 1'b0;
   localparam logic SEL_Q = 1'b1;
endpackage

// File: rtl/record_fifo.sv
// Single record queue with explicit occupancy count; a pop on a full queue
// frees the slot that a same-cycle push then fills.
module record_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 11
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     push_drop,
   output logic                     pop_fail
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop    = pop && !empty;
      pop_fail  = pop && empty;
      do_push   = push && (!full || do_pop);
      push_drop = push && !do_push;
      wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d   = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; the pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/parking_record_buffer.sv
// Captures {token, time} records on P/Q enable rising edges into two queues
// drained through one registered read port with sticky error status.
module parking_record_buffer
   import parking_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TOKEN_W = TOKEN_W_DEF,
   parameter int TIME_W  = TIME_W_DEF
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [TIME_W-1:0]           time_data,
   input  logic [TOKEN_W-1:0]          user_token,
   input  logic                        P_register_enable,
   input  logic                        Q_register_enable,
   input  logic                        read_req,
   input  logic                        read_sel,
   output logic [TOKEN_W+TIME_W-1:0]   read_data,
   output logic                        read_valid,
   output logic [$clog2(DEPTH):0]      p_count,
   output logic [$clog2(DEPTH):0]      q_count,
   output logic                        p_full,
   output logic                        p_empty,
   output logic                        q_full,
   output logic                        q_empty,
   output logic [1:0]                  overflow,
   output logic                        underflow
);
   localparam int REC_W = TOKEN_W + TIME_W;

   logic             p_en_d_q, q_en_d_q;
   logic             p_push, q_push, p_pop, q_pop;
   logic             p_drop, q_drop, p_fail, q_fail;
   logic [REC_W-1:0] rec_in, p_dout, q_dout;
   logic [REC_W-1:0] read_data_q, read_data_d;
   logic             read_valid_q, read_valid_d;
   logic [1:0]       overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   assign rec_in = {user_token, time_data};
   assign p_push = P_register_enable & ~p_en_d_q;
   assign q_push = Q_register_enable & ~q_en_d_q;
   assign p_pop  = read_req && (read_sel == SEL_P);
   assign q_pop  = read_req && (read_sel == SEL_Q);

   record_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_p_fifo (
      .clock(clock), .reset(reset), .push(p_push), .pop(p_pop), .din(rec_in),
      .dout(p_dout), .count(p_count), .full(p_full), .empty(p_empty),
      .push_drop(p_drop), .pop_fail(p_fail)
   );

   record_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_q_fifo (
      .clock(clock), .reset(reset), .push(q_push), .pop(q_pop), .din(rec_in),
      .dout(q_dout), .count(q_count), .full(q_full), .empty(q_empty),
      .push_drop(q_drop), .pop_fail(q_fail)
   );

   always_comb begin
      read_valid_d = (p_pop && !p_fail) || (q_pop && !q_fail);
      read_data_d  = read_data_q;
      if (read_valid_d) read_data_d = (read_sel == SEL_Q) ? q_dout : p_dout;
      overflow_d   = overflow_q | {q_drop, p_drop};
      underflow_d  = underflow_q | p_fail | q_fail;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_en_d_q     <= 1'b0;
         q_en_d_q     <= 1'b0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         overflow_q   <= '0;
         underflow_q  <= 1'b0;
      end else begin
         p_en_d_q     <= P_register_enable;
         q_en_d_q     <= Q_register_enable;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
endmodule

// File: tb/tb_parking_record_buffer.sv
// Bench for parking_record_buffer: constant vector table plus model-queue sequences.
module tb_parking_record_buffer;
   import parking_pkg::*;

   localparam int DEPTH = 4;
   localparam int RW    = REC_W_DEF;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [7:0]      time_data = '0;
   logic [2:0]      user_token = '0;
   logic            P_register_enable = 1'b0, Q_register_enable = 1'b0;
   logic            read_req = 1'b0, read_sel = 1'b0;
   logic [RW-1:0]   read_data;
   logic            read_valid;
   logic [2:0]      p_count, q_count;
   logic            p_full, p_empty, q_full, q_empty;
   logic [1:0]      overflow;
   logic            underflow;

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] p_model[$];
   logic [RW-1:0] q_model[$];
   logic [RW-1:0] last_data;
   logic [1:0]    exp_ovf;

   typedef struct {
      logic pe; logic qe; logic [2:0] tok; logic [7:0] tm; logic rd; logic sel;
      logic [2:0] pc; logic [2:0] qc; logic vld; logic [RW-1:0] data; logic ufl;
   } vec_t;
   vec_t tbl[11];

   parking_record_buffer #(.DEPTH(DEPTH), .TOKEN_W(3), .TIME_W(8)) dut (
      .clock(clock), .reset(reset), .time_data(time_data), .user_token(user_token),
      .P_register_enable(P_register_enable), .Q_register_enable(Q_register_enable),
      .read_req(read_req), .read_sel(read_sel), .read_data(read_data),
      .read_valid(read_valid), .p_count(p_count), .q_count(q_count),
      .p_full(p_full), .p_empty(p_empty), .q_full(q_full), .q_empty(q_empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic capture(input logic pe, input logic qe, input logic [2:0] tok, input logic [7:0] tm);
      user_token = tok;
      time_data  = tm;
      P_register_enable = pe;
      Q_register_enable = qe;
      step();
      if (pe) begin
         if (p_model.size() < DEPTH) p_model.push_back({tok, tm}); else exp_ovf[0] = 1'b1;
      end
      if (qe) begin
         if (q_model.size() < DEPTH) q_model.push_back({tok, tm}); else exp_ovf[1] = 1'b1;
      end
      P_register_enable = 1'b0;
      Q_register_enable = 1'b0;
      step();
   endtask

   task automatic pop(input logic sel);
      logic [RW-1:0] exp;
      int sz;
      read_req = 1'b1;
      read_sel = sel;
      step();
      read_req = 1'b0;
      sz = (sel == SEL_Q) ? q_model.size() : p_model.size();
      if (sz > 0) begin
         exp = (sel == SEL_Q) ? q_model.pop_front() : p_model.pop_front();
         chk("pop_valid", 32'(read_valid), 32'd1);
         chk("pop_data", 32'(read_data), 32'(exp));
         last_data = exp;
      end else begin
         chk("empty_pop_valid", 32'(read_valid), 32'd0);
         chk("empty_pop_data_hold", 32'(read_data), 32'(last_data));
         chk("empty_pop_underflow", 32'(underflow), 32'd1);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 11'h000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 11'h000, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 11'h000, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 11'h000, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 11'h000, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 3'd5, 8'hF3, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 11'h5F3, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 3'd5, 8'hF3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 11'h5F3, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 3'd0, 8'h42, 1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 11'h5F3, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h42, 1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 11'h042, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h42, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 11'h042, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h42, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 11'h042, 1'b1};
      exp_ovf   = 2'b00;
      last_data = '0;

      // Reset state
      #12;
      chk("rst_read_data", 32'(read_data), 32'd0);
      chk("rst_read_valid", 32'(read_valid), 32'd0);
      chk("rst_counts", {p_count, q_count}, 32'd0);
      chk("rst_flags", {p_full, p_empty, q_full, q_empty}, 32'b0101);
      chk("rst_sticky", {overflow, underflow}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Held enable, simultaneous enables, empty-queue pop
      for (int i = 0; i < 11; i++) begin
         P_register_enable = tbl[i].pe;
         Q_register_enable = tbl[i].qe;
         user_token = tbl[i].tok;
         time_data  = tbl[i].tm;
         read_req   = tbl[i].rd;
         read_sel   = tbl[i].sel;
         step();
         chk($sformatf("tbl%0d_p_count", i), 32'(p_count), 32'(tbl[i].pc));
         chk($sformatf("tbl%0d_q_count", i), 32'(q_count), 32'(tbl[i].qc));
         chk($sformatf("tbl%0d_valid", i), 32'(read_valid), 32'(tbl[i].vld));
         chk($sformatf("tbl%0d_data", i), 32'(read_data), 32'(tbl[i].data));
         chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].ufl));
      end
      P_register_enable = 1'b0;
      Q_register_enable = 1'b0;
      read_req = 1'b0;
      step();
      last_data = 11'h042;

      // Fill and overflow Q
      for (int t = 1; t <= 5; t++) capture(1'b0, 1'b1, 3'(t), 8'(t));
      chk("q_full", 32'(q_full), 32'd1);
      chk("q_count_full", 32'(q_count), 32'd4);
      chk("overflow_q", 32'(overflow), 32'(exp_ovf));
      chk("overflow_q_const", 32'(overflow), 32'b10);
      for (int k = 0; k < 4; k++) pop(SEL_Q);
      chk("q_empty_after_drain", 32'(q_empty), 32'd1);

      // Full P queue: push and pop in the same cycle
      for (int t = 0; t < 4; t++) capture(1'b1, 1'b0, 3'(t), 8'h10 + 8'(t));
      chk("p_full", 32'(p_full), 32'd1);
      P_register_enable = 1'b1;
      user_token = 3'd7;
      time_data  = 8'h14;
      read_req   = 1'b1;
      read_sel   = SEL_P;
      step();
      P_register_enable = 1'b0;
      read_req = 1'b0;
      chk("fullpp_valid", 32'(read_valid), 32'd1);
      chk("fullpp_data", 32'(read_data), 32'(p_model.pop_front()));
      p_model.push_back({3'd7, 8'h14});
      chk("fullpp_count", 32'(p_count), 32'd4);
      chk("fullpp_no_ovf", 32'(overflow[0]), 32'd0);
      last_data = read_data;
      step();
      for (int k = 0; k < 4; k++) pop(SEL_P);
      chk("p_empty_after_drain", 32'(p_empty), 32'd1);

      // Empty P queue: push and pop in the same cycle
      P_register_enable = 1'b1;
      user_token = 3'd2;
      time_data  = 8'h77;
      read_req   = 1'b1;
      read_sel   = SEL_P;
      step();
      P_register_enable = 1'b0;
      read_req = 1'b0;
      chk("emptypp_valid", 32'(read_valid), 32'd0);
      chk("emptypp_data_hold", 32'(read_data), 32'(last_data));
      chk("emptypp_count", 32'(p_count), 32'd1);
      p_model.push_back({3'd2, 8'h77});
      step();
      pop(SEL_P);

      // Pointer wrap on P
      for (int k = 0; k < 10; k++) begin
         capture(1'b1, 1'b0, 3'(k), 8'hA0 + 8'(k));
         pop(SEL_P);
      end
      chk("wrap_p_empty", 32'(p_empty), 32'd1);

      // Asynchronous reset mid-operation
      for (int k = 0; k < 3; k++) capture(1'b1, 1'b0, 3'(k), 8'hC0 + 8'(k));
      chk("pre_reset_p_count", 32'(p_count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_counts", {p_count, q_count}, 32'd0);
      chk("mid_rst_empty", {p_empty, q_empty}, 32'b11);
      chk("mid_rst_sticky", {overflow, underflow}, 32'd0);
      chk("mid_rst_read", {read_valid, read_data}, 32'd0);
      p_model.delete();
      q_model.delete();
      last_data = '0;
      exp_ovf   = 2'b00;
      @(negedge clock);
      reset = 1'b1;
      step();
      pop(SEL_P);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
